// File: rtl/gps_sample_packer.sv
// Packs 1-bit or 2-bit GPS front-end samples into 16-bit words (oldest sample in the MSBs)
// and queues them in a first-word-fall-through FIFO drained by the host bridge.
module gps_sample_packer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  hb_clk,
  input  logic                  ha_rst,
  input  logic                  sample_stb,
  input  logic [1:0]            sample,
  input  logic                  mode,
  input  logic                  gps_rd,
  output logic [15:0]           gps_dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovfl,
  output logic                  udfl
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [1:0]            rst_q;
  logic                  hold;
  logic [15:0]           sr, sr_n;
  logic [3:0]            bc;
  logic                  wmode, eff_mode, last;
  logic                  stb, rd, push, push_ok, pop_ok, empty, full;
  logic [DEPTH_LOG2:0]   wptr, rptr, wptr_n, rptr_n, count_n;
  logic [15:0]           dout_n;
  logic [15:0]           mem [DEPTH];

  // Release is synchronised; hold drops once the first stage has cleared, so the
  // second edge after ha_rst falls is the first one that acts on inputs.
  always_ff @(posedge hb_clk or posedge ha_rst) begin
    if (ha_rst) rst_q <= 2'b11;
    else        rst_q <= {rst_q[0], 1'b0};
  end
  assign hold = rst_q[0] & rst_q[1];

  always_comb begin
    stb      = sample_stb & ~hold;
    rd       = gps_rd & ~hold;
    eff_mode = (bc == 4'd0) ? mode : wmode;
    sr_n     = eff_mode ? {sr[13:0], sample} : {sr[14:0], sample[1]};
    last     = eff_mode ? (bc == 4'd7) : (bc == 4'd15);
    push     = stb & last;
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    pop_ok   = rd & ~empty;
    push_ok  = push & (~full | pop_ok);
    wptr_n   = wptr + {{DEPTH_LOG2{1'b0}}, push_ok};
    rptr_n   = rptr + {{DEPTH_LOG2{1'b0}}, pop_ok};
    count_n  = wptr_n - rptr_n;
    // The new head may be the word being written this very cycle.
    if (count_n == '0)
      dout_n = 16'h0000;
    else if (push_ok && (rptr_n == wptr))
      dout_n = sr_n;
    else
      dout_n = mem[rptr_n[DEPTH_LOG2-1:0]];
  end

  assign count = wptr - rptr;

  always_ff @(posedge hb_clk or posedge ha_rst) begin
    if (ha_rst) begin
      sr       <= '0;
      bc       <= '0;
      wmode    <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      gps_dout <= '0;
      ovfl     <= 1'b0;
      udfl     <= 1'b0;
    end else begin
      if (stb) begin
        sr <= sr_n;
        bc <= last ? 4'd0 : bc + 4'd1;
        if (bc == 4'd0) wmode <= mode;
      end
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      gps_dout <= dout_n;
      if (push && !push_ok) ovfl <= 1'b1;
      if (rd && empty)      udfl <= 1'b1;
    end
  end

  always_ff @(posedge hb_clk) begin
    if (push_ok) mem[wptr[DEPTH_LOG2-1:0]] <= sr_n;
  end

endmodule

// File: tb/tb_gps_sample_packer.sv
// Directed bench for gps_sample_packer: reset release, packing modes, FIFO
// overflow/underflow corners and asynchronous reset mid-operation.
module tb_gps_sample_packer;

  logic        hb_clk = 1'b0;
  logic        ha_rst = 1'b1;
  logic        sample_stb = 1'b0;
  logic [1:0]  sample = 2'b00;
  logic        mode = 1'b0;
  logic        gps_rd = 1'b0;
  logic [15:0] gps_dout;
  logic [4:0]  count;
  logic        ovfl, udfl;

  int n_cmp = 0;
  int n_err = 0;

  gps_sample_packer #(.DEPTH_LOG2(4)) dut (
    .hb_clk(hb_clk), .ha_rst(ha_rst), .sample_stb(sample_stb), .sample(sample),
    .mode(mode), .gps_rd(gps_rd), .gps_dout(gps_dout), .count(count),
    .ovfl(ovfl), .udfl(udfl)
  );

  always #5 hb_clk = ~hb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the rising edge, then release the strobes.
  task automatic clk_step(input logic stb, input logic [1:0] s, input logic m, input logic rd);
    sample_stb = stb;
    sample     = s;
    mode       = m;
    gps_rd     = rd;
    @(posedge hb_clk);
    #1;
    sample_stb = 1'b0;
    gps_rd     = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w, input logic m, input logic rd_last);
    logic [15:0] wv;
    wv = w;
    if (m) begin
      for (int i = 0; i < 8; i++)
        clk_step(1'b1, wv[15-2*i -: 2], 1'b1, rd_last && (i == 7));
    end else begin
      for (int i = 0; i < 16; i++)
        clk_step(1'b1, {wv[15-i], 1'b0}, 1'b0, rd_last && (i == 15));
    end
  endtask

  task automatic do_reset();
    ha_rst = 1'b1;
    #1;
    chk("rst_dout", 32'(gps_dout), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ovfl", 32'(ovfl), 32'h0);
    chk("rst_udfl", 32'(udfl), 32'h0);
    @(negedge hb_clk);
    ha_rst = 1'b0;
    clk_step(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and release
    repeat (3) @(posedge hb_clk);
    #1;
    chk("init_dout", 32'(gps_dout), 32'h0);
    chk("init_count", 32'(count), 32'h0);
    chk("init_ovfl", 32'(ovfl), 32'h0);
    chk("init_udfl", 32'(udfl), 32'h0);
    @(negedge hb_clk);
    ha_rst = 1'b0;
    clk_step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("rel_ignored", 32'(count), 32'h0);
    for (int i = 0; i < 15; i++) clk_step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("rel_15", 32'(count), 32'h0);
    clk_step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("rel_count", 32'(count), 32'h1);
    chk("rel_dout", 32'(gps_dout), 32'hFFFF);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("rel_pop_dout", 32'(gps_dout), 32'h0);
    chk("rel_pop_count", 32'(count), 32'h0);
    chk("rel_pop_udfl", 32'(udfl), 32'h0);

    // 2-bit packing
    for (int i = 0; i < 7; i++) clk_step(1'b1, (i % 2 == 0) ? 2'b11 : 2'b00, 1'b1, 1'b0);
    chk("m2_7", 32'(count), 32'h0);
    clk_step(1'b1, 2'b00, 1'b1, 1'b0);
    chk("m2_count", 32'(count), 32'h1);
    chk("m2_dout", 32'(gps_dout), 32'hCCCC);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);

    // Mode change mid-word
    for (int i = 0; i < 3; i++) clk_step(1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) clk_step(1'b1, 2'b10, 1'b1, 1'b0);
    chk("mid_15", 32'(count), 32'h0);
    clk_step(1'b1, 2'b10, 1'b1, 1'b0);
    chk("mid_count", 32'(count), 32'h1);
    chk("mid_dout", 32'(gps_dout), 32'hFFFF);
    for (int i = 0; i < 8; i++) clk_step(1'b1, 2'b10, 1'b1, 1'b0);
    chk("mid_next_count", 32'(count), 32'h2);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("mid_next_dout", 32'(gps_dout), 32'hAAAA);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("mid_empty", 32'(count), 32'h0);

    // Overflow
    for (int i = 0; i < 16; i++) push_word((i % 2 == 0) ? 16'hAAAA : 16'h5555, 1'b1, 1'b0);
    chk("full_count", 32'(count), 32'h10);
    chk("full_ovfl", 32'(ovfl), 32'h0);
    push_word(16'h1234, 1'b1, 1'b0);
    chk("ovf_count", 32'(count), 32'h10);
    chk("ovf_flag", 32'(ovfl), 32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", 32'(gps_dout), (i % 2 == 0) ? 32'hAAAA : 32'h5555);
      clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    end
    chk("ovf_drained_dout", 32'(gps_dout), 32'h0);
    chk("ovf_drained_count", 32'(count), 32'h0);

    // Push with same-cycle pop at full
    do_reset();
    for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i), 1'b1, 1'b0);
    chk("pp_full", 32'(count), 32'h10);
    push_word(16'hBEEF, 1'b1, 1'b1);
    chk("pp_count", 32'(count), 32'h10);
    chk("pp_ovfl", 32'(ovfl), 32'h0);
    chk("pp_head", 32'(gps_dout), 32'h0101);
    for (int i = 0; i < 16; i++) begin
      chk("pp_drain", 32'(gps_dout), (i < 15) ? 32'h0101 + 32'(i) : 32'hBEEF);
      clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    end
    chk("pp_udfl", 32'(udfl), 32'h0);

    // Underflow and empty output
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("udf_flag", 32'(udfl), 32'h1);
    chk("udf_dout", 32'(gps_dout), 32'h0);
    chk("udf_count", 32'(count), 32'h0);
    push_word(16'h8001, 1'b0, 1'b0);
    chk("b2b_c1", 32'(count), 32'h1);
    chk("b2b_h1", 32'(gps_dout), 32'h8001);
    push_word(16'h7FFE, 1'b0, 1'b0);
    chk("b2b_c2", 32'(count), 32'h2);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("b2b_h2", 32'(gps_dout), 32'h7FFE);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);
    chk("b2b_h0", 32'(gps_dout), 32'h0);
    chk("b2b_c0", 32'(count), 32'h0);
    push_word(16'h3C3C, 1'b1, 1'b1);
    chk("pp0_count", 32'(count), 32'h1);
    chk("pp0_dout", 32'(gps_dout), 32'h3C3C);
    clk_step(1'b0, 2'b00, 1'b0, 1'b1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) push_word(16'h1111 * 16'(i + 1), 1'b1, 1'b0);
    chk("mo_count", 32'(count), 32'h5);
    for (int i = 0; i < 7; i++) clk_step(1'b1, 2'b11, 1'b1, 1'b0);
    do_reset();
    push_word(16'h1234, 1'b1, 1'b0);
    chk("mo_post_count", 32'(count), 32'h1);
    chk("mo_post_dout", 32'(gps_dout), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
